demux16_buf: RTL and testbench
==============================

# demux16_buf

Write-side counterpart of the 16:1 read-select mux. It takes a single 32-bit stream of (lane select, data) writes under a valid/ready handshake. Each write is steered into one of 16 lane holding registers. A lane holds its word and a valid flag until its consumer acknowledges it. The block sits between a single producer (write-back or MMIO store path) and 16 independent consumers, so each consumer sees only its own lane's word and valid flag.

## Interface
- WIDTH, 32, data width per lane
- LANES, 16, lane count; fixed at 16, select width 4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- iData  in  32  write data
- iSel  in  4  target lane, 0..15
- iValid  in  1  write request
- oReady  out  1  write accepted this cycle when high with iValid
- iFlush  in  1  synchronous clear of all lane valid flags
- iAck  in  16  per-lane consume strobe; bit k consumes lane k
- oData  out  512  lane k word at bits [32k+31:32k]
- oValid  out  16  per-lane holding flag
- oAcceptCnt  out  16  count of accepted writes, wrapping

## Operation
- Accept condition: iValid && oReady && !iFlush.
- oReady is combinational: `!iFlush && (!oValid[iSel] || iAck[iSel])`.
  - oReady depends on iSel, iAck and iFlush in the same cycle.
  - oReady is independent of iValid.
- On accept:
  - lane[iSel] data <= iData.
  - oValid[iSel] <= 1.
  - oAcceptCnt <= oAcceptCnt + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
- Ack, lane k with oValid[k]=1: oValid[k] <= 0, unless a write to lane k is accepted in the same cycle.
  - In that case oValid[k] stays 1 and the data takes the new word.
- Ack on an empty lane (oValid[k]=0) is ignored.
- Data registers are never cleared by ack or flush; they keep the last written word.
- Flush:
  - All oValid bits <= 0 at the next edge.
  - No write is accepted in the flush cycle, because oReady=0.
  - Acks in that cycle are irrelevant.
  - oAcceptCnt is unchanged.
- Writes to lanes other than iSel are never blocked by iSel's occupancy. Each lane is independent.
- No internal state machine beyond per-lane full/empty. Each lane has two states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ack with no same-cycle write.
  - FULL -> FULL on ack plus write.
  - any -> EMPTY on flush.

## Timing
- Reset (rst_n=0, asynchronous): oValid=16'h0000, all oData=0, oAcceptCnt=0. oReady is combinational and reads 1 during reset only if iFlush=0.
- Write latency: 1 cycle. Data accepted at edge N is visible on oData and oValid from edge N onward.
- Ack latency: oValid[k] falls at the edge where iAck[k] is sampled high.
- Throughput: 1 write per cycle.
  - Back-to-back writes to the same lane sustain only if the consumer acks every cycle.
  - Otherwise the second write stalls with oReady=0 until ack.
- Producer rule: while iValid=1 and oReady=0, iData and iSel must hold stable.
- Reset asserted mid-transfer: all lanes empty, counter 0; any in-flight write is lost.
- Simultaneous ack and write on different lanes: both take effect in the same edge.

## Structure
- Package demux_pkg holds:
  - WIDTH=32, LANES=16, SEL_W=4
  - LANE_EMPTY and LANE_FULL encodings
- Sub-module demux_lane, instantiated 16 times by generate:
  - one WIDTH-bit data register plus valid flag
  - inputs: write-enable, data, ack, flush
  - outputs: data, valid
- Top level contains:
  - the select decoder (4 -> 16 one-hot write enables gated by accept)
  - the oReady mux over oValid and iAck
  - the accept counter

## Test plan
- Reset then write:
  - Stimulus: after rst_n release, iSel=3, iData=0xDEADBEEF, iValid=1 for one cycle.
  - Required: oValid=16'h0008; oData[127:96]=0xDEADBEEF; oAcceptCnt=1; all other lanes 0.
- Full-lane stall:
  - Stimulus: lane 5 full; write iSel=5, iData=0x11111111 with iAck=0 for 3 cycles, then iAck[5]=1.
  - Required: oReady=0 for 3 cycles; on the ack cycle oReady=1 and the write is accepted; lane 5 holds 0x11111111; oValid[5] stays 1 throughout.
- Ack without write:
  - Stimulus: lanes 0 and 15 full; iAck=16'h8001, iValid=0.
  - Required: oValid=0 next cycle; lane data unchanged; an ack to empty lane 7 has no effect.
- Flush priority:
  - Stimulus: lanes 1, 2 and 9 full; iFlush=1 with iValid=1, iSel=4.
  - Required: oReady=0; oValid=0 next cycle; lane 4 not written; oAcceptCnt unchanged.
- Counter wrap and async reset:
  - Stimulus: 65536 accepted writes round-robin over lanes with acks, then rst_n pulsed low mid-cycle during a write.
  - Required: oAcceptCnt returns to 0x0000 after write 65536; on rst_n low, oValid and oData clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared widths and lane state encodings for demux16_buf
package demux_pkg;
  localparam int WIDTH = 32;
  localparam int LANES = 16;
  localparam int SEL_W = 4;
  typedef enum logic {LANE_EMPTY = 1'b0, LANE_FULL = 1'b1} lane_state_t;
endpackage

// File: rtl/demux_lane.sv
// demux_lane: one holding register with full/empty flag
// Ports: clk, rst_n, wen (accepted write), wdata, ack (consume), flush (clear flag),
//        data (held word), valid (lane full)
module demux_lane
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ack,
  input  logic             flush,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  lane_state_t state, state_nx;
  // A same-cycle write beats an ack so the lane stays full with the new word.
  always_comb state_nx = flush ? LANE_EMPTY : wen ? LANE_FULL : ack ? LANE_EMPTY : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LANE_EMPTY;
      data  <= '0;
    end else begin
      state <= state_nx;
      if (wen) data <= wdata;
    end
  assign valid = (state == LANE_FULL);
endmodule

// File: rtl/demux16_buf.sv
// demux16_buf: steer a valid/ready write stream into 16 acked lane holding registers
// Ports: clk, rst_n, iData/iSel/iValid/oReady (write handshake), iFlush (clear all flags),
//        iAck (per-lane consume), oData (lane k at [32k+31:32k]), oValid, oAcceptCnt
module demux16_buf
  import demux_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       iData,
  input  logic [SEL_W-1:0]       iSel,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic                   iFlush,
  input  logic [LANES-1:0]       iAck,
  output logic [WIDTH*LANES-1:0] oData,
  output logic [LANES-1:0]       oValid,
  output logic [15:0]            oAcceptCnt
);
  logic             accept;
  logic [LANES-1:0] wen;
  // A full lane frees up this cycle if its consumer acks it.
  assign oReady = !iFlush && (!oValid[iSel] || iAck[iSel]);
  assign accept = iValid && oReady;
  assign wen    = accept ? (LANES'(1) << iSel) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) oAcceptCnt <= '0;
    else if (accept) oAcceptCnt <= oAcceptCnt + 16'd1;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (wen[g]),
      .wdata (iData),
      .ack   (iAck[g]),
      .flush (iFlush),
      .data  (oData[WIDTH*g +: WIDTH]),
      .valid (oValid[g])
    );
  end
endmodule

// File: tb/tb_demux16_buf.sv
// tb_demux16_buf: directed self-checking bench for demux16_buf
module tb_demux16_buf;
  logic         clk = 0;
  logic         rst_n = 0;
  logic [31:0]  iData = 0;
  logic [3:0]   iSel = 0;
  logic         iValid = 0;
  logic         oReady;
  logic         iFlush = 0;
  logic [15:0]  iAck = 0;
  logic [511:0] oData;
  logic [15:0]  oValid;
  logic [15:0]  oAcceptCnt;
  int checks = 0;
  int failures = 0;

  demux16_buf dut (
    .clk(clk), .rst_n(rst_n), .iData(iData), .iSel(iSel), .iValid(iValid),
    .oReady(oReady), .iFlush(iFlush), .iAck(iAck), .oData(oData),
    .oValid(oValid), .oAcceptCnt(oAcceptCnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [31:0] d);
    iSel = sel; iData = d; iValid = 1; iAck = 0;
    tick();
    iValid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #2;
    checks++; if (oValid !== 16'h0) begin failures++; $display("FAIL reset_valid got=%h exp=0000", oValid); end
    checks++; if (oData !== '0) begin failures++; $display("FAIL reset_data got nonzero lanes"); end
    checks++; if (oAcceptCnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", oAcceptCnt); end
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", oReady); end
    iFlush = 1; #1;
    checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL reset_ready_flush got=%b exp=0", oReady); end
    iFlush = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset_write;
    logic [511:0] m;
    wr(4'd3, 32'hDEADBEEF);
    m = oData; m[127:96] = '0;
    checks++; if (oValid !== 16'h0008) begin failures++; $display("FAIL rw_valid got=%h exp=0008", oValid); end
    checks++; if (oData[127:96] !== 32'hDEADBEEF) begin failures++; $display("FAIL rw_data got=%h exp=deadbeef", oData[127:96]); end
    checks++; if (oAcceptCnt !== 16'd1) begin failures++; $display("FAIL rw_cnt got=%0d exp=1", oAcceptCnt); end
    checks++; if (m !== '0) begin failures++; $display("FAIL rw_other_lanes got nonzero exp=0"); end
  endtask

  task automatic test_stall;
    wr(4'd5, 32'hAAAA5555);
    iSel = 4'd5; iData = 32'h11111111; iValid = 1; iAck = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL stall_ready%0d got=%b exp=0", i, oReady); end
      tick();
      checks++; if (oValid[5] !== 1'b1 || oData[191:160] !== 32'hAAAA5555) begin failures++; $display("FAIL stall_hold%0d got v=%b d=%h exp v=1 d=aaaa5555", i, oValid[5], oData[191:160]); end
    end
    iAck = 16'h0020; #1;
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL stall_ack_ready got=%b exp=1", oReady); end
    tick();
    iValid = 0; iAck = 0;
    checks++; if (oValid[5] !== 1'b1 || oData[191:160] !== 32'h11111111) begin failures++; $display("FAIL stall_write got v=%b d=%h exp v=1 d=11111111", oValid[5], oData[191:160]); end
    checks++; if (oAcceptCnt !== 16'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", oAcceptCnt); end
  endtask

  task automatic test_ack;
    wr(4'd0, 32'h01010101);
    wr(4'd15, 32'hF0F0F0F0);
    checks++; if (oValid !== 16'h8029) begin failures++; $display("FAIL ack_pre got=%h exp=8029", oValid); end
    iAck = 16'h8081;
    tick();
    iAck = 0;
    checks++; if (oValid !== 16'h0028) begin failures++; $display("FAIL ack_valid got=%h exp=0028", oValid); end
    checks++; if (oData[31:0] !== 32'h01010101 || oData[511:480] !== 32'hF0F0F0F0) begin failures++; $display("FAIL ack_data got l0=%h l15=%h exp 01010101 f0f0f0f0", oData[31:0], oData[511:480]); end
    checks++; if (oData[255:224] !== 32'h0 || oAcceptCnt !== 16'd5) begin failures++; $display("FAIL ack_empty got l7=%h cnt=%0d exp 0 5", oData[255:224], oAcceptCnt); end
  endtask

  task automatic test_back_to_back;
    iSel = 4'd7; iData = 32'h77777777; iValid = 1; iAck = 16'h0008;
    tick();
    iValid = 0; iAck = 0;
    checks++; if (oValid !== 16'h00A0) begin failures++; $display("FAIL b2b_valid got=%h exp=00a0", oValid); end
    checks++; if (oData[255:224] !== 32'h77777777 || oAcceptCnt !== 16'd6) begin failures++; $display("FAIL b2b_data got l7=%h cnt=%0d exp 77777777 6", oData[255:224], oAcceptCnt); end
  endtask

  task automatic test_flush;
    wr(4'd1, 32'h1);
    wr(4'd2, 32'h2);
    wr(4'd9, 32'h9);
    checks++; if (oValid !== 16'h02A6) begin failures++; $display("FAIL flush_pre got=%h exp=02a6", oValid); end
    iFlush = 1; iValid = 1; iSel = 4'd4; iData = 32'h44444444; #1;
    checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", oReady); end
    tick();
    iFlush = 0; iValid = 0;
    checks++; if (oValid !== 16'h0) begin failures++; $display("FAIL flush_valid got=%h exp=0000", oValid); end
    checks++; if (oData[159:128] !== 32'h0 || oAcceptCnt !== 16'd9) begin failures++; $display("FAIL flush_nowrite got l4=%h cnt=%0d exp 0 9", oData[159:128], oAcceptCnt); end
    checks++; if (oData[63:32] !== 32'h1) begin failures++; $display("FAIL flush_keep got l1=%h exp 1", oData[63:32]); end
  endtask

  task automatic test_wrap;
    rst_n = 0; tick(); rst_n = 1; tick();
    iValid = 1; iAck = 16'hFFFF;
    for (int i = 0; i < 65536; i++) begin
      iSel = i[3:0]; iData = i;
      tick();
      if (i == 65534) begin
        checks++; if (oAcceptCnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", oAcceptCnt); end
      end
    end
    checks++; if (oAcceptCnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", oAcceptCnt); end
    checks++; if (oValid !== 16'h8000) begin failures++; $display("FAIL wrap_valid got=%h exp=8000", oValid); end
    iAck = 0; iSel = 4'd2; iData = 32'hCAFEF00D;
    #3;
    rst_n = 0;
    #1;
    checks++; if (oValid !== 16'h0 || oData !== '0) begin failures++; $display("FAIL async_clear got valid=%h exp 0000 and zero data", oValid); end
    checks++; if (oAcceptCnt !== 16'h0) begin failures++; $display("FAIL async_cnt got=%h exp=0000", oAcceptCnt); end
    iValid = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_write();
    test_stall();
    test_ack();
    test_back_to_back();
    test_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
